// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed integer divider (restoring, one step per clock).
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   data_operandA/B         dividend / divisor, sampled on the start edge only
//   ctrl_DIV                one-cycle start pulse; restarts any operation in flight
//   data_result             registered quotient, held until next completion or reset
//   data_exception          divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY          one-cycle completion pulse
//   busy                    high while an operation is in flight
module seq_divider #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] b_mag;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             div0;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             last_step;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
  assign a_abs  = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign b_abs  = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
  assign b_zero = (data_operandB == '0);

  // One restoring step: shift the next dividend bit into the remainder, trial-subtract.
  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, b_mag};
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; a start pulse wins in every state
  always_comb begin
    state_nxt = state;
    if (ctrl_DIV) begin
      state_nxt = b_zero ? DONE : RUN;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     if (last_step) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem            <= '0;
      quo            <= '0;
      b_mag          <= '0;
      cnt            <= '0;
      sign_q         <= 1'b0;
      div0           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_DIV) begin
      rem            <= '0;
      quo            <= a_abs;
      b_mag          <= b_abs;
      cnt            <= '0;
      sign_q         <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0           <= b_zero;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          // trial[WIDTH] set means the subtraction went negative: keep the shifted remainder
          rem            <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          quo            <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt            <= cnt + CNT_W'(1);
          data_resultRDY <= 1'b0;
        end
        DONE: begin
          data_result    <= div0 ? '0 : (sign_q ? -quo : quo);
          data_exception <= div0;
          data_resultRDY <= 1'b1;
          busy           <= 1'b0;
        end
        default: begin
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on ready.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // Reference: signed division truncating toward zero, done in 64-bit arithmetic, low W bits kept.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    return W'(q);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b0 && data_resultRDY === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no ready (result %0h, t=%0t)",
                 data_result, $time);
      end else begin
        mon_e = sbq.pop_front();
        check("result",        longint'(data_result),    longint'(mon_e.res));
        check("exception",     longint'(data_exception), longint'(mon_e.exc));
        check("latency",       longint'(cyc),            longint'(mon_e.at));
        check("busy_at_ready", longint'(busy),           0);
      end
    end
  end

  // Issue a start pulse; a new start cancels whatever was outstanding.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_DIV      = 1'b1;
    sbq.delete();
    e.exc = (y == '0);
    e.res = e.exc ? '0 : ref_quot(x, y);
    e.at  = cyc + 1 + (e.exc ? 1 : int'(W) + 1);
    sbq.push_back(e);
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(output logic [W-1:0] last_res);
    int n;
    n = 0;
    last_res = '0;
    while (sbq.size() != 0 && n < 100) begin
      last_res = sbq[0].res;
      @(negedge clock);
      n++;
    end
    check("done_timeout", longint'(sbq.size()), 0);
  endtask

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    issue(x, y);
    wait_done(r);
  endtask

  logic [W-1:0] held;
  logic [W-1:0] rx, ry;

  initial begin
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", longint'(data_result),    0);
    check("reset_rdy",    longint'(data_resultRDY), 0);
    check("reset_busy",   longint'(busy),           0);
    check("reset_exc",    longint'(data_exception), 0);
    reset = 1'b0;

    // Basic op with busy window and result hold
    issue(32'd100, 32'd7);
    check("busy_after_start", longint'(busy), 1);
    repeat (31) @(negedge clock);
    check("busy_before_done", longint'(busy), 1);
    wait_done(held);
    @(negedge clock);
    check("result_hold", longint'(data_result), longint'(held));
    check("rdy_one_cycle", longint'(data_resultRDY), 0);

    // Sign combinations and boundaries
    run_one(-32'sd7, 32'd2);
    run_one(32'd7, -32'sd2);
    run_one(-32'sd7, -32'sd2);
    run_one(32'h8000_0000, 32'hFFFF_FFFF);
    run_one(32'h8000_0000, 32'd1);
    run_one(32'd3, 32'd10);

    // Divide by zero, then exception clears on the next start
    run_one(32'd5, 32'd0);
    issue(32'd9, 32'd3);
    check("exc_clear_on_start", longint'(data_exception), 0);
    wait_done(held);

    // Restart mid-operation: only the second op completes
    issue(32'd100, 32'd7);
    repeat (8) @(negedge clock);
    run_one(32'd50, 32'd5);

    // Asynchronous reset mid-operation
    run_one(32'd100, 32'd7);
    issue(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    #2 reset = 1'b1;
    sbq.delete();
    #1;
    check("async_rst_result", longint'(data_result),    0);
    check("async_rst_rdy",    longint'(data_resultRDY), 0);
    check("async_rst_busy",   longint'(busy),           0);
    check("async_rst_exc",    longint'(data_exception), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run_one(32'd50, 32'd5);

    // Randomized operands, with occasional aborted starts
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: begin rx = $urandom; ry = $urandom; end
        1: begin rx = W'($signed($urandom_range(0, 400)) - 200); ry = W'($signed($urandom_range(0, 40)) - 20); end
        2: begin rx = $urandom; ry = '0; end
        3: begin rx = 32'h8000_0000; ry = W'($signed($urandom_range(0, 8)) - 4); end
        4: begin rx = $urandom; ry = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1; end
        default: begin rx = $urandom_range(0, 50); ry = $urandom_range(51, 1000); end
      endcase
      if ($urandom_range(0, 4) == 0) begin
        issue($urandom, $urandom_range(1, 1000));
        repeat ($urandom_range(0, 30)) @(negedge clock);
      end
      run_one(rx, ry);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed integer divider; the subtract-side counterpart to the ripple adder datapath. It sits in the ALU/multdiv unit beside the adder.
- Computes quotient = dividend / divisor using one shift-and-subtract (restoring) step per clock.
- Reports divide-by-zero as an exception.
- Start is a one-cycle control pulse; completion is a one-cycle ready pulse, matching the multdiv handshake used by the CPU stall logic.

Parameters:
- WIDTH, 32, operand and result width in bits; two's-complement signed.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_operandA  input  WIDTH  dividend; sampled only on the start edge.
- data_operandB  input  WIDTH  divisor; sampled only on the start edge.
- ctrl_DIV  input  1  start pulse; sampled at the rising edge.
- data_result  output  WIDTH  quotient, registered.
- data_exception  output  1  divide-by-zero flag; valid when data_resultRDY=1.
- data_resultRDY  output  1  one-cycle completion pulse.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; counter=0.
  - Remainder, quotient and latched operand registers cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Any in-flight operation is discarded; no ready pulse is produced for it.
- States: IDLE, RUN, DONE.
- Start (edge E0): ctrl_DIV=1 at a rising edge in any state.
  - Latch |A| and |B| into the working registers.
  - Latch sign_q = A[WIDTH-1] XOR B[WIDTH-1].
  - Remainder register cleared; counter=0; go to RUN; busy=1.
- Divide-by-zero: if B==0 at E0, go to DONE directly instead of RUN.
  - At E1: data_resultRDY=1, data_exception=1, data_result=0.
- RUN: one step per edge, E1..E_WIDTH.
  - {rem, q} shifted left by 1.
  - trial = rem_shifted - |B|, computed in WIDTH+1 bits.
  - trial non-negative: rem = trial and q[0] = 1. Otherwise rem is kept and q[0] = 0.
  - Counter increments; after step WIDTH (edge E_WIDTH) go to DONE.
- DONE, edge E_(WIDTH+1), i.e. E33 for the default width:
  - data_result = sign_q ? -q : q, two's-complement negation modulo 2^WIDTH.
  - data_resultRDY=1 for exactly one cycle; data_exception=0; busy=0; go to IDLE.
- Total latency: ready is high in the cycle after edge E33, i.e. 33 cycles after start for WIDTH=32.
- Rounding: quotient truncates toward zero. The remainder is internal only and not output.
- Overflow: most-negative / -1 gives |A| = 2^(WIDTH-1) unsigned, so the quotient wraps to 0x80000000 with no exception.
- Magnitude: |A| of the most-negative value is 2^(WIDTH-1); the working registers hold it unsigned without loss.
- Result hold and ready:
  - data_result holds its value until the next completion or reset.
  - data_exception is cleared at the next start edge.
  - data_resultRDY is 0 in every cycle except the completion cycle.
- Restart while busy: ctrl_DIV=1 in RUN or DONE aborts the current operation and restarts with the new operands. The aborted operation produces no ready pulse.
- ctrl_DIV held high for multiple cycles is treated as a restart on every edge; the CPU issues single-cycle pulses.
- Operand changes after E0 have no effect.

Test Plan:
- Pulse ctrl_DIV with A=100, B=7 -> exactly 33 cycles later data_resultRDY=1 for one cycle, data_result=14, data_exception=0; busy high for 33 cycles.
- Sign combinations with |A|=7, |B|=2: (-7)/2, 7/(-2), (-7)/(-2) -> results 0xFFFFFFFD (-3), 0xFFFFFFFD (-3), 3.
- A=5, B=0 -> ready one cycle after start with data_exception=1, data_result=0.
- Boundaries:
  - A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, no exception.
  - A=0x80000000, B=1 -> result 0x80000000.
  - A=3, B=10 -> result 0.
- Start A=100, B=7; at cycle 10 pulse ctrl_DIV with A=50, B=5 -> single ready 33 cycles after the second pulse, result 10; no ready pulse for the first operation.
- Assert reset at cycle 20 of an operation -> outputs go to 0 immediately (asynchronously), no ready pulse afterwards; a new start after reset deassertion completes normally.
